dm_access_unit: RTL and testbench



---
 rtl/dm_access_unit.sv | 217 +++++++++++++++++++++
 tb/tb_dm_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - RV32I data-memory access unit
// Decodes loads/stores onto a ROM/RAM/IO map with lane alignment, sign extension and faults.
module dm_access_unit #(
  parameter logic [31:0] ROM_BASE     = 32'h0000_0000,
  parameter int          ROM_SIZE_LOG = 12,
  parameter logic [31:0] RAM_BASE     = 32'h1000_0000,
  parameter int          RAM_SIZE_LOG = 16,
  parameter logic [31:0] IO_BASE      = 32'h8000_0000,
  parameter int          IO_CHANNELS  = 4,
  parameter int          IO_CH_LOG    = 8,
  parameter int          IO_TIMEOUT   = 15
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [31:0]             req_addr_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_signed_i,
  output logic                    rsp_valid_o,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_fault_o,
  output logic [1:0]              rsp_cause_o,
  output logic [ROM_SIZE_LOG-3:0] rom_addr_o,
  input  logic [31:0]             rom_rdata_i,
  output logic [RAM_SIZE_LOG-3:0] ram_addr_o,
  output logic                    ram_we_o,
  output logic [3:0]              ram_be_o,
  output logic [31:0]             ram_wdata_o,
  input  logic [31:0]             ram_rdata_i,
  output logic                    io_valid_o,
  output logic [IO_CHANNELS-1:0]  io_sel_o,
  output logic [IO_CH_LOG-1:0]    io_addr_o,
  output logic                    io_we_o,
  output logic [3:0]              io_be_o,
  output logic [31:0]             io_wdata_o,
  input  logic                    io_ready_i,
  input  logic [31:0]             io_rdata_i
);

  // The IO window always spans 16 channel slots; slots past IO_CHANNELS fault.
  localparam int IO_REG_LOG = IO_CH_LOG + 4;
  localparam int CW         = $clog2(IO_TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, MEM, IO_WAIT, IO_RESP} state_t;

  state_t state_q, state_d;

  logic                   fault_q, we_q, sgn_q, rom_sel_q;
  logic [1:0]             cause_q, off_q, size_q;
  logic [31:0]            io_rdata_q;
  logic                   io_valid_q, io_we_q;
  logic [IO_CHANNELS-1:0] io_sel_q;
  logic [IO_CH_LOG-1:0]   io_addr_q;
  logic [3:0]             io_be_q;
  logic [31:0]            io_wdata_q;
  logic [CW-1:0]          cnt_q;

  logic       accept, mem_go, io_go, timeout_hit;
  logic       rom_hit, ram_hit, io_hit, ch_ok, misaligned;
  logic       dec_fault;
  logic [1:0] dec_cause, size_eff, off;
  logic [3:0] ch_idx, be_c;
  logic [31:0] wdata_c;

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] o,
                                          input logic [1:0] sz, input logic sgn);
    logic [31:0] sh;
    sh = d >> {o, 3'b000};
    case (sz)
      2'd0:    extract = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: extract = d;
    endcase
  endfunction

  assign size_eff   = (req_size_i == 2'd3) ? 2'd2 : req_size_i;
  assign off        = req_addr_i[1:0];
  assign rom_hit    = req_addr_i[31:ROM_SIZE_LOG] == ROM_BASE[31:ROM_SIZE_LOG];
  assign ram_hit    = req_addr_i[31:RAM_SIZE_LOG] == RAM_BASE[31:RAM_SIZE_LOG];
  assign io_hit     = req_addr_i[31:IO_REG_LOG] == IO_BASE[31:IO_REG_LOG];
  assign ch_idx     = req_addr_i[IO_REG_LOG-1:IO_CH_LOG];
  assign ch_ok      = {28'd0, ch_idx} < 32'(IO_CHANNELS);
  assign misaligned = ((size_eff == 2'd1) && off[0]) || ((size_eff == 2'd2) && (off != 2'd0));

  always_comb begin
    dec_fault = 1'b1;
    dec_cause = 2'd2;
    if (misaligned)                 dec_cause = 2'd1;
    else if (rom_hit && req_we_i)   dec_cause = 2'd2;
    else if (rom_hit || ram_hit)    dec_fault = 1'b0;
    else if (io_hit && ch_ok)       dec_fault = 1'b0;
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_wdata_i;
    case (size_eff)
      2'd0: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        be_c    = 4'b0011 << off;
        wdata_c = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == IDLE) || (state_q == MEM);
  assign accept      = req_valid_i && req_ready_o && !reset_i;
  assign mem_go      = accept && (dec_fault || rom_hit || ram_hit);
  assign io_go       = accept && !mem_go;
  assign timeout_hit = (IO_TIMEOUT != 0) && (cnt_q == CW'(IO_TIMEOUT - 1));

  // Memory ports are driven straight from the request so data returns one cycle later.
  assign rom_addr_o  = req_addr_i[ROM_SIZE_LOG-1:2];
  assign ram_addr_o  = req_addr_i[RAM_SIZE_LOG-1:2];
  assign ram_we_o    = accept && !dec_fault && ram_hit && req_we_i;
  assign ram_be_o    = be_c;
  assign ram_wdata_o = wdata_c;

  assign io_valid_o = io_valid_q;
  assign io_sel_o   = io_sel_q;
  assign io_addr_o  = io_addr_q;
  assign io_we_o    = io_we_q;
  assign io_be_o    = io_be_q;
  assign io_wdata_o = io_wdata_q;

  always_comb begin
    state_d     = state_q;
    rsp_valid_o = 1'b0;
    rsp_fault_o = 1'b0;
    rsp_cause_o = 2'd0;
    rsp_rdata_o = 32'd0;
    case (state_q)
      IDLE, MEM: begin
        if (state_q == MEM) begin
          rsp_valid_o = 1'b1;
          rsp_fault_o = fault_q;
          rsp_cause_o = cause_q;
          if (!fault_q && !we_q)
            rsp_rdata_o = extract(rom_sel_q ? rom_rdata_i : ram_rdata_i, off_q, size_q, sgn_q);
        end
        if (mem_go)     state_d = MEM;
        else if (io_go) state_d = IO_WAIT;
        else            state_d = IDLE;
      end
      IO_WAIT: begin
        if (io_ready_i || timeout_hit) state_d = IO_RESP;
      end
      IO_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_fault_o = fault_q;
        rsp_cause_o = cause_q;
        if (!fault_q && !we_q) rsp_rdata_o = extract(io_rdata_q, off_q, size_q, sgn_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      fault_q    <= 1'b0;
      cause_q    <= 2'd0;
      we_q       <= 1'b0;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      sgn_q      <= 1'b0;
      rom_sel_q  <= 1'b0;
      io_rdata_q <= 32'd0;
      io_valid_q <= 1'b0;
      io_sel_q   <= '0;
      io_addr_q  <= '0;
      io_we_q    <= 1'b0;
      io_be_q    <= 4'd0;
      io_wdata_q <= 32'd0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fault_q   <= dec_fault;
        cause_q   <= dec_fault ? dec_cause : 2'd0;
        we_q      <= req_we_i;
        off_q     <= off;
        size_q    <= size_eff;
        sgn_q     <= req_signed_i;
        rom_sel_q <= rom_hit;
      end
      if (io_go) begin
        io_valid_q <= 1'b1;
        io_sel_q   <= IO_CHANNELS'(1) << ch_idx;
        io_addr_q  <= req_addr_i[IO_CH_LOG-1:0];
        io_we_q    <= req_we_i;
        io_be_q    <= be_c;
        io_wdata_q <= wdata_c;
        cnt_q      <= '0;
      end else if (state_q == IO_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (io_ready_i) begin
          io_valid_q <= 1'b0;
          io_rdata_q <= io_rdata_i;
        end else if (timeout_hit) begin
          io_valid_q <= 1'b0;
          fault_q    <= 1'b1;
          cause_q    <= 2'd3;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - directed self-checking bench for dm_access_unit
// Behavioural ROM/RAM models with one-cycle read latency; IO handshake driven per test.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_cause;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_valid, io_we, io_ready;
  logic [3:0]  io_sel, io_be;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram_mem [0:16383];
  logic [31:0] ram_mask;

  always #5 clk = ~clk;

  dm_access_unit dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_signed_i(req_signed),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_fault_o(rsp_fault),
    .rsp_cause_o(rsp_cause),
    .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .io_valid_o(io_valid), .io_sel_o(io_sel), .io_addr_o(io_addr), .io_we_o(io_we),
    .io_be_o(io_be), .io_wdata_o(io_wdata), .io_ready_i(io_ready), .io_rdata_i(io_rdata)
  );

  assign ram_mask = {{8{ram_be[3]}}, {8{ram_be[2]}}, {8{ram_be[1]}}, {8{ram_be[0]}}};

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_mask) | (ram_wdata & ram_mask);
    ram_rdata <= ram_mem[ram_addr];
    rom_rdata <= 32'h8091A2B3 ^ {22'd0, rom_addr};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sgn);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    req_size   = sz;
    req_signed = sgn;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0;
    tick; tick;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_fault: got %b want 0", rsp_fault); end
    n_checks++; if (rsp_cause !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_cause: got %0d want 0", rsp_cause); end
    n_checks++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (io_valid !== 1'b0) begin n_fail++; $display("FAIL reset_io_valid: got %b want 0", io_valid); end
    n_checks++; if (io_sel !== 4'd0) begin n_fail++; $display("FAIL reset_io_sel: got %b want 0000", io_sel); end
    n_checks++; if (io_we !== 1'b0) begin n_fail++; $display("FAIL reset_io_we: got %b want 0", io_we); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    reset = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_store_byte_load;
    drive(1'b1, 32'h10000010, 32'hDEADBEEF, 2'd2, 1'b0);
    #1;
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL sw_ram_we: got %b want 1", ram_we); end
    n_checks++; if (ram_be !== 4'b1111) begin n_fail++; $display("FAIL sw_ram_be: got %b want 1111", ram_be); end
    n_checks++; if (ram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_ram_wdata: got %h want deadbeef", ram_wdata); end
    n_checks++; if (ram_addr !== 14'h0004) begin n_fail++; $display("FAIL sw_ram_addr: got %h want 0004", ram_addr); end
    tick;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'd0)
      begin n_fail++; $display("FAIL sw_rsp: got v=%b f=%b d=%h want v=1 f=0 d=0", rsp_valid, rsp_fault, rsp_rdata); end
    drive(1'b0, 32'h10000013, 32'd0, 2'd0, 1'b1);
    #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL lb_ram_we: got %b want 0", ram_we); end
    tick;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFFFDE)
      begin n_fail++; $display("FAIL lb_signed: got v=%b d=%h want v=1 d=ffffffde", rsp_valid, rsp_rdata); end
    drive(1'b0, 32'h10000013, 32'd0, 2'd0, 1'b0);
    tick;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000000DE)
      begin n_fail++; $display("FAIL lbu: got v=%b d=%h want v=1 d=000000de", rsp_valid, rsp_rdata); end
    req_valid = 1'b0;
    tick;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lbu_single_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_half_store;
    drive(1'b1, 32'h10000002, 32'hABCD1234, 2'd1, 1'b0);
    #1;
    n_checks++; if (ram_be !== 4'b1100) begin n_fail++; $display("FAIL sh_ram_be: got %b want 1100", ram_be); end
    n_checks++; if (ram_wdata !== 32'h12341234) begin n_fail++; $display("FAIL sh_ram_wdata: got %h want 12341234", ram_wdata); end
    tick;
    drive(1'b0, 32'h10000002, 32'd0, 2'd1, 1'b1);
    tick;
    n_checks++; if (rsp_rdata !== 32'h00001234) begin n_fail++; $display("FAIL lh_signed_pos: got %h want 00001234", rsp_rdata); end
    drive(1'b1, 32'h10000020, 32'h11223344, 2'd3, 1'b0);
    #1;
    n_checks++; if (ram_be !== 4'b1111) begin n_fail++; $display("FAIL size3_be: got %b want 1111", ram_be); end
    tick;
    req_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 32'h10000010, 32'd0, 2'd2, 1'b0);
    tick;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL b2b_lw0: got v=%b d=%h want v=1 d=deadbeef", rsp_valid, rsp_rdata); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    drive(1'b0, 32'h10000000, 32'd0, 2'd2, 1'b0);
    tick;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12340000)
      begin n_fail++; $display("FAIL b2b_lw1: got v=%b d=%h want v=1 d=12340000", rsp_valid, rsp_rdata); end
    drive(1'b0, 32'h00000104, 32'd0, 2'd2, 1'b0);
    tick;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8091A2F2)
      begin n_fail++; $display("FAIL b2b_rom_lw: got v=%b d=%h want v=1 d=8091a2f2", rsp_valid, rsp_rdata); end
    drive(1'b0, 32'h00000106, 32'd0, 2'd1, 1'b1);
    tick;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF8091)
      begin n_fail++; $display("FAIL b2b_rom_lh: got v=%b d=%h want v=1 d=ffff8091", rsp_valid, rsp_rdata); end
    drive(1'b0, 32'h10000020, 32'd0, 2'd2, 1'b0);
    tick;
    n_checks++; if (rsp_rdata !== 32'h11223344) begin n_fail++; $display("FAIL b2b_size3_read: got %h want 11223344", rsp_rdata); end
    req_valid = 1'b0;
    tick;
  endtask

  task automatic test_faults;
    logic        we_t   [6];
    logic [31:0] addr_t [6];
    logic [1:0]  size_t [6];
    logic [1:0]  cause_t[6];
    we_t[0] = 1'b0; addr_t[0] = 32'h10000002; size_t[0] = 2'd2; cause_t[0] = 2'd1;
    we_t[1] = 1'b1; addr_t[1] = 32'h00000100; size_t[1] = 2'd2; cause_t[1] = 2'd2;
    we_t[2] = 1'b0; addr_t[2] = 32'h40000000; size_t[2] = 2'd2; cause_t[2] = 2'd2;
    we_t[3] = 1'b0; addr_t[3] = 32'h80000400; size_t[3] = 2'd2; cause_t[3] = 2'd2;
    we_t[4] = 1'b1; addr_t[4] = 32'h10000001; size_t[4] = 2'd1; cause_t[4] = 2'd1;
    we_t[5] = 1'b1; addr_t[5] = 32'h00000003; size_t[5] = 2'd1; cause_t[5] = 2'd1;
    for (int i = 0; i < 6; i++) begin
      drive(we_t[i], addr_t[i], 32'hFFFFFFFF, size_t[i], 1'b0);
      #1;
      n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL fault%0d_ram_we: got %b want 0", i, ram_we); end
      tick;
      req_valid = 1'b0;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_cause !== cause_t[i] || rsp_rdata !== 32'd0)
        begin n_fail++; $display("FAIL fault%0d_rsp: got v=%b f=%b c=%0d d=%h want v=1 f=1 c=%0d d=0",
                                 i, rsp_valid, rsp_fault, rsp_cause, rsp_rdata, cause_t[i]); end
      n_checks++; if (io_valid !== 1'b0) begin n_fail++; $display("FAIL fault%0d_io_valid: got %b want 0", i, io_valid); end
      tick;
    end
  endtask

  task automatic test_io_read;
    io_ready = 1'b0;
    drive(1'b0, 32'h80000104, 32'd0, 2'd2, 1'b0);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (io_valid !== 1'b1 || io_sel !== 4'b0010 || io_addr !== 8'h04 || io_we !== 1'b0)
        begin n_fail++; $display("FAIL io_rd_fields%0d: got v=%b sel=%b a=%h we=%b want v=1 sel=0010 a=04 we=0",
                                 i, io_valid, io_sel, io_addr, io_we); end
      n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0)
        begin n_fail++; $display("FAIL io_rd_wait%0d: got ready=%b rsp=%b want 0 0", i, req_ready, rsp_valid); end
      tick;
    end
    io_ready = 1'b1; io_rdata = 32'hCAFEF00D;
    n_checks++; if (io_valid !== 1'b1) begin n_fail++; $display("FAIL io_rd_valid_at_ready: got %b want 1", io_valid); end
    tick;
    io_ready = 1'b0; io_rdata = 32'd0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'hCAFEF00D)
      begin n_fail++; $display("FAIL io_rd_rsp: got v=%b f=%b d=%h want v=1 f=0 d=cafef00d", rsp_valid, rsp_fault, rsp_rdata); end
    n_checks++; if (io_valid !== 1'b0 || req_ready !== 1'b0)
      begin n_fail++; $display("FAIL io_rd_resp_state: got io_valid=%b ready=%b want 0 0", io_valid, req_ready); end
    tick;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin n_fail++; $display("FAIL io_rd_idle: got rsp=%b ready=%b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_io_write;
    drive(1'b1, 32'h80000005, 32'h00000077, 2'd0, 1'b0);
    tick;
    req_valid = 1'b0;
    io_ready = 1'b1;
    n_checks++; if (io_valid !== 1'b1 || io_we !== 1'b1 || io_be !== 4'b0010 || io_sel !== 4'b0001 || io_addr !== 8'h05)
      begin n_fail++; $display("FAIL io_wr_ctl: got v=%b we=%b be=%b sel=%b a=%h want 1 1 0010 0001 05",
                               io_valid, io_we, io_be, io_sel, io_addr); end
    n_checks++; if (io_wdata !== 32'h77777777) begin n_fail++; $display("FAIL io_wr_wdata: got %h want 77777777", io_wdata); end
    tick;
    io_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'd0)
      begin n_fail++; $display("FAIL io_wr_rsp: got v=%b f=%b d=%h want v=1 f=0 d=0", rsp_valid, rsp_fault, rsp_rdata); end
    tick;
  endtask

  task automatic test_io_timeout;
    int hi = 0;
    int rsp_at = 0;
    logic       got_fault = 1'b0;
    logic [1:0] got_cause = 2'd0;
    logic [31:0] got_rdata = 32'hX;
    io_ready = 1'b0;
    drive(1'b0, 32'h80000300, 32'd0, 2'd2, 1'b0);
    tick;
    req_valid = 1'b0;
    n_checks++; if (io_sel !== 4'b1000) begin n_fail++; $display("FAIL to_io_sel: got %b want 1000", io_sel); end
    for (int i = 1; i <= 40 && rsp_at == 0; i++) begin
      if (io_valid === 1'b1) hi++;
      if (rsp_valid === 1'b1) begin
        rsp_at = i; got_fault = rsp_fault; got_cause = rsp_cause; got_rdata = rsp_rdata;
      end
      tick;
    end
    n_checks++; if (hi != 15) begin n_fail++; $display("FAIL to_io_valid_cycles: got %0d want 15", hi); end
    n_checks++; if (rsp_at != 16) begin n_fail++; $display("FAIL to_rsp_latency: got %0d want 16", rsp_at); end
    n_checks++; if (got_fault !== 1'b1 || got_cause !== 2'd3 || got_rdata !== 32'd0)
      begin n_fail++; $display("FAIL to_rsp: got f=%b c=%0d d=%h want f=1 c=3 d=0", got_fault, got_cause, got_rdata); end
  endtask

  task automatic test_ready_at_timeout;
    io_ready = 1'b0;
    drive(1'b0, 32'h80000000, 32'd0, 2'd2, 1'b0);
    tick;
    req_valid = 1'b0;
    repeat (14) tick;
    n_checks++; if (io_valid !== 1'b1) begin n_fail++; $display("FAIL rt_valid_last: got %b want 1", io_valid); end
    io_ready = 1'b1; io_rdata = 32'h0BADC0DE;
    tick;
    io_ready = 1'b0; io_rdata = 32'd0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'h0BADC0DE)
      begin n_fail++; $display("FAIL rt_ready_wins: got v=%b f=%b d=%h want v=1 f=0 d=0badc0de", rsp_valid, rsp_fault, rsp_rdata); end
    tick;
  endtask

  task automatic test_reset_mid_io;
    int seen = 0;
    io_ready = 1'b0;
    drive(1'b0, 32'h80000200, 32'd0, 2'd2, 1'b0);
    tick;
    req_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_checks++; if (io_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin n_fail++; $display("FAIL rst_io: got io_valid=%b rsp=%b ready=%b want 0 0 1", io_valid, rsp_valid, req_ready); end
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) seen++;
      tick;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_no_rsp: got %0d responses want 0", seen); end
    drive(1'b0, 32'h10000010, 32'd0, 2'd2, 1'b0);
    tick;
    req_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL rst_recover: got v=%b d=%h want v=1 d=deadbeef", rsp_valid, rsp_rdata); end
    tick;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram_mem[i] = 32'd0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'd0; req_signed = 1'b0; io_ready = 1'b0; io_rdata = 32'd0;
    test_reset;
    test_word_store_byte_load;
    test_half_store;
    test_back_to_back;
    test_faults;
    test_io_read;
    test_io_write;
    test_io_timeout;
    test_ready_at_timeout;
    test_reset_mid_io;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
